// File: rtl/pgr_uart_reg_bridge_32bit_if.sv
// pgr_uart_reg_bridge_32bit_if: FIFO byte ports and register bus of the UART register bridge.
interface pgr_uart_reg_bridge_32bit_if;
   logic [7:0]  rx_fifo_rd_data;
   logic        rx_fifo_rd_data_valid;
   logic        rx_fifo_rd_data_req;
   logic [7:0]  tx_fifo_wr_data;
   logic        tx_fifo_wr_data_valid;
   logic        tx_fifo_wr_data_req;
   logic [31:0] reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_wr;
   logic        reg_rd;
   logic [31:0] reg_rdata;
   logic        reg_ack;
   logic        frame_err;
   logic        bus_err;
   modport master (
      input  rx_fifo_rd_data, rx_fifo_rd_data_valid, tx_fifo_wr_data_valid, reg_rdata, reg_ack,
      output rx_fifo_rd_data_req, tx_fifo_wr_data, tx_fifo_wr_data_req, reg_addr, reg_wdata,
             reg_wr, reg_rd, frame_err, bus_err
   );
   modport slave (
      output rx_fifo_rd_data, rx_fifo_rd_data_valid, tx_fifo_wr_data_valid, reg_rdata, reg_ack,
      input  rx_fifo_rd_data_req, tx_fifo_wr_data, tx_fifo_wr_data_req, reg_addr, reg_wdata,
             reg_wr, reg_rd, frame_err, bus_err
   );
endinterface

// File: rtl/pgr_uart_reg_bridge_32bit.sv
// pgr_uart_reg_bridge_32bit: parses framed 32-bit register commands from the RX FIFO,
// runs them on a req/ack register bus and pushes the response bytes into the TX FIFO.
module pgr_uart_reg_bridge_32bit #(
   parameter logic [15:0] FRAME_TIMEOUT = 16'd50000,
   parameter logic [15:0] BUS_TIMEOUT   = 16'd255
) (
   input logic                          clk,
   input logic                          rst,
   pgr_uart_reg_bridge_32bit_if.master  io
);
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;
   state_t      r_state;
   logic        r_op_wr;
   logic [1:0]  r_bcnt;
   logic [15:0] r_fcnt;
   logic [15:0] r_tcnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_resp;
   logic        r_wr;
   logic        r_rd;
   logic        r_ferr;
   logic        r_berr;
   logic        w_in_frame;
   logic        w_ftmo;
   logic        w_pop;
   logic        w_push;
   logic        w_last;
   assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATA);
   assign w_ftmo     = w_in_frame && (r_fcnt == FRAME_TIMEOUT);
   // a byte presented in the timeout cycle stays in the FIFO for the next frame
   assign w_pop      = io.rx_fifo_rd_data_valid && (w_in_frame || r_state == S_IDLE) && !w_ftmo;
   assign w_push     = (r_state == S_RESP) && io.tx_fifo_wr_data_valid;
   assign w_last     = r_op_wr || (r_bcnt == 2'd3);
   assign io.rx_fifo_rd_data_req = w_pop;
   assign io.tx_fifo_wr_data_req = w_push;
   assign io.tx_fifo_wr_data     = r_resp[31:24];
   assign io.reg_addr            = r_addr;
   assign io.reg_wdata           = r_wdata;
   assign io.reg_wr              = r_wr;
   assign io.reg_rd              = r_rd;
   assign io.frame_err           = r_ferr;
   assign io.bus_err             = r_berr;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op_wr <= 1'b0;
         r_bcnt  <= 2'd0;
         r_fcnt  <= 16'd0;
         r_tcnt  <= 16'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_resp  <= 32'd0;
         r_wr    <= 1'b0;
         r_rd    <= 1'b0;
         r_ferr  <= 1'b0;
         r_berr  <= 1'b0;
      end else begin
         r_ferr <= 1'b0;
         r_berr <= 1'b0;
         r_fcnt <= w_pop ? 16'd0 : (w_in_frame && r_fcnt != 16'hFFFF) ? r_fcnt + 16'd1 : r_fcnt;
         case (r_state)
            S_IDLE: if (w_pop) begin
               if (io.rx_fifo_rd_data == 8'h57 || io.rx_fifo_rd_data == 8'h52) begin
                  r_op_wr <= io.rx_fifo_rd_data == 8'h57;
                  r_bcnt  <= 2'd0;
                  r_state <= S_ADDR;
               end else
                  r_ferr <= 1'b1;
            end
            S_ADDR: if (w_ftmo) begin
               r_state <= S_IDLE;
               r_ferr  <= 1'b1;
            end else if (w_pop) begin
               r_addr <= {r_addr[23:0], io.rx_fifo_rd_data};
               r_bcnt <= r_bcnt + 2'd1;
               if (r_bcnt == 2'd3) begin
                  r_state <= r_op_wr ? S_DATA : S_BUS;
                  r_rd    <= !r_op_wr;
                  r_tcnt  <= 16'd0;
               end
            end
            S_DATA: if (w_ftmo) begin
               r_state <= S_IDLE;
               r_ferr  <= 1'b1;
            end else if (w_pop) begin
               r_wdata <= {r_wdata[23:0], io.rx_fifo_rd_data};
               r_bcnt  <= r_bcnt + 2'd1;
               if (r_bcnt == 2'd3) begin
                  r_state <= S_BUS;
                  r_wr    <= 1'b1;
                  r_tcnt  <= 16'd0;
               end
            end
            // ack wins over a timeout landing in the same cycle
            S_BUS: if (io.reg_ack) begin
               r_wr    <= 1'b0;
               r_rd    <= 1'b0;
               r_resp  <= r_op_wr ? 32'h4B00_0000 : io.reg_rdata;
               r_bcnt  <= 2'd0;
               r_state <= S_RESP;
            end else if (r_tcnt == BUS_TIMEOUT) begin
               r_wr    <= 1'b0;
               r_rd    <= 1'b0;
               r_berr  <= 1'b1;
               r_resp  <= r_op_wr ? 32'h4500_0000 : 32'hFFFF_FFFF;
               r_bcnt  <= 2'd0;
               r_state <= S_RESP;
            end else if (r_tcnt != 16'hFFFF)
               r_tcnt <= r_tcnt + 16'd1;
            S_RESP: if (w_push) begin
               r_resp <= {r_resp[23:0], 8'h00};
               r_bcnt <= r_bcnt + 2'd1;
               if (w_last) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pgr_uart_reg_bridge_32bit.sv
// tb_pgr_uart_reg_bridge_32bit: scoreboard bench; expected bus accesses and TX bytes are queued
// from the frame rules when stimulus is issued and popped by monitors as the DUT produces them.
module tb_pgr_uart_reg_bridge_32bit;
   localparam logic [15:0] FT = 16'd300;
   localparam logic [15:0] BT = 16'd40;
   typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] wdata;} bus_t;
   typedef struct {int dly; logic [31:0] rdata; bit hang;} plan_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   pgr_uart_reg_bridge_32bit_if io();
   pgr_uart_reg_bridge_32bit #(.FRAME_TIMEOUT(FT), .BUS_TIMEOUT(BT)) dut (.clk(clk), .rst(rst), .io(io));
   bus_t       q_bus[$];
   logic [7:0] q_tx[$];
   plan_t      q_plan[$];
   int errs = 0, checks = 0, cyc = 0, last_pop = 0;
   int exp_ferr = 0, exp_berr = 0, ferr_cnt = 0, berr_cnt = 0, max_gap = 0;
   bit stall_mode = 0, rand_bp = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string msg);
      checks++;
      errs++;
      $display("FAIL %s (cycle %0d)", msg, cyc);
   endtask

   // bus request monitor, error pulse counters
   initial begin
      bus_t e;
      logic prev = 1'b0;
      forever begin
         @(negedge clk);
         if (io.frame_err) ferr_cnt++;
         if (io.bus_err) berr_cnt++;
         if ((io.reg_wr || io.reg_rd) && !prev) begin
            if (q_bus.size() == 0) fail($sformatf("bus_unexp: got wr=%0b rd=%0b addr=%h, expected no access", io.reg_wr, io.reg_rd, io.reg_addr));
            else begin
               e = q_bus.pop_front();
               chk("bus_op", {62'd0, io.reg_wr, io.reg_rd}, {62'd0, e.wr, !e.wr});
               chk("bus_addr", {32'd0, io.reg_addr}, {32'd0, e.addr});
               if (e.wr) chk("bus_wdata", {32'd0, io.reg_wdata}, {32'd0, e.wdata});
               chk("bus_latency", 64'(cyc - last_pop), 64'd1);
            end
         end
         prev = io.reg_wr || io.reg_rd;
      end
   end

   // register bus responder
   initial begin
      plan_t p;
      bit seen = 0;
      io.reg_ack = 1'b0;
      io.reg_rdata = 32'd0;
      forever begin
         @(negedge clk);
         if ((io.reg_wr || io.reg_rd) && !seen) begin
            seen = 1;
            if (q_plan.size() != 0) begin
               p = q_plan.pop_front();
               if (!p.hang) begin
                  repeat (p.dly) @(posedge clk);
                  @(posedge clk);
                  #1 io.reg_ack = 1'b1;
                  io.reg_rdata = p.rdata;
                  @(posedge clk);
                  #1 io.reg_ack = 1'b0;
                  io.reg_rdata = $urandom;
               end
            end
         end
         if (!(io.reg_wr || io.reg_rd)) seen = 0;
      end
   end

   // TX FIFO space: optional random backpressure, or a 20-cycle stall after each push
   initial begin
      bit p;
      int stall_left = 0;
      io.tx_fifo_wr_data_valid = 1'b1;
      forever begin
         @(negedge clk);
         p = io.tx_fifo_wr_data_req;
         @(posedge clk);
         #1;
         if (p && stall_mode) stall_left = 20;
         else if (stall_left > 0) stall_left--;
         io.tx_fifo_wr_data_valid = (stall_left == 0) && (!rand_bp || $urandom_range(3) != 0);
      end
   end

   // TX monitor
   initial begin
      int ack_c = 0;
      bit armed = 0;
      forever begin
         @(negedge clk);
         if (io.reg_ack && (io.reg_wr || io.reg_rd)) begin
            ack_c = cyc;
            armed = 1;
         end
         if (io.tx_fifo_wr_data_req) begin
            if (!io.tx_fifo_wr_data_valid) fail("tx_push_when_full: got push, expected none while FIFO full");
            if (q_tx.size() == 0) fail($sformatf("tx_unexp: got byte %h, expected no push", io.tx_fifo_wr_data));
            else chk("tx_byte", {56'd0, io.tx_fifo_wr_data}, {56'd0, q_tx.pop_front()});
            if (armed && !rand_bp) chk("tx_latency", 64'(cyc - ack_c), 64'd1);
            armed = 0;
         end
      end
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: got no finish, expected finish within 90000 cycles");
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      int g = $urandom_range(max_gap);
      repeat (g) begin
         @(posedge clk);
         #1;
      end
      io.rx_fifo_rd_data = b;
      io.rx_fifo_rd_data_valid = 1'b1;
      @(negedge clk);
      while (!io.rx_fifo_rd_data_req && n < 1000) begin
         n++;
         @(negedge clk);
      end
      if (!io.rx_fifo_rd_data_req) fail($sformatf("rx_pop_timeout: byte %h never consumed", b));
      else last_pop = cyc;
      @(posedge clk);
      #1 io.rx_fifo_rd_data_valid = 1'b0;
   endtask

   task automatic send_rd(input logic [31:0] a);
      send_byte(8'h52);
      for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
   endtask

   task automatic send_wr(input logic [31:0] a, input logic [31:0] d);
      send_byte(8'h57);
      for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
      for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
   endtask

   // reference model: an ack issued more than BT cycles after the first request cycle is too late
   task automatic expect_txn(input bit wr, input logic [31:0] a, input logic [31:0] d, input int dly, input bit hang);
      bus_t e;
      plan_t p;
      bit to = hang || (dly + 1 > int'(BT));
      e.wr = wr;
      e.addr = a;
      e.wdata = wr ? d : 32'd0;
      q_bus.push_back(e);
      p.dly = dly;
      p.rdata = d;
      p.hang = hang;
      q_plan.push_back(p);
      if (wr) q_tx.push_back(to ? 8'h45 : 8'h4B);
      else for (int i = 3; i >= 0; i--) q_tx.push_back(to ? 8'hFF : d[8*i +: 8]);
      if (to) exp_berr++;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] d, input int dly, input bit hang);
      expect_txn(0, a, d, dly, hang);
      send_rd(a);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input int dly, input bit hang);
      expect_txn(1, a, d, dly, hang);
      send_wr(a, d);
   endtask

   task automatic drain();
      int n = 0;
      while ((q_tx.size() != 0 || q_bus.size() != 0) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      if (q_tx.size() != 0 || q_bus.size() != 0) begin
         fail($sformatf("drain_timeout: got %0d tx and %0d bus items pending, expected 0", q_tx.size(), q_bus.size()));
         q_tx.delete();
         q_bus.delete();
         q_plan.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic chk_errs();
      chk("frame_err_count", 64'(ferr_cnt), 64'(exp_ferr));
      chk("bus_err_count", 64'(berr_cnt), 64'(exp_berr));
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_reg_addr"}, {32'd0, io.reg_addr}, 64'd0);
      chk({tag, "_ctl"}, {18'd0, io.rx_fifo_rd_data_req, io.tx_fifo_wr_data_req, io.tx_fifo_wr_data,
          io.reg_wdata, io.reg_wr, io.reg_rd, io.frame_err, io.bus_err}, 64'd0);
   endtask

   initial begin
      logic [7:0] b;
      io.rx_fifo_rd_data = 8'd0;
      io.rx_fifo_rd_data_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_outs_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      wr(32'h0000_1004, 32'hDEAD_BEEF, 2, 0);
      drain();
      rd(32'h0000_0008, 32'h1234_5678, 1, 0);
      drain();
      send_byte(8'h33);
      exp_ferr++;
      rd(32'hA5A5_0010, 32'h0BAD_F00D, 0, 0);
      drain();
      chk_errs();
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h00);
      repeat (int'(FT) + 20) @(posedge clk);
      #1 exp_ferr++;
      chk_errs();
      rd(32'h0000_0000, 32'hCAFE_0001, 3, 0);
      drain();
      send_byte(8'h52);
      for (int i = 0; i < 3; i++) send_byte(8'h00);
      repeat (int'(FT)) @(posedge clk);
      #1 exp_ferr++;
      rd(32'h0101_0202, 32'h7766_5544, 0, 0);
      drain();
      chk_errs();
      rd(32'h0000_0C00, 32'h1111_2222, 0, 1);
      drain();
      wr(32'h0000_0C04, 32'h3333_4444, 0, 1);
      drain();
      rd(32'h0000_0C08, 32'h5566_7788, int'(BT) - 1, 0);
      drain();
      rd(32'h0000_0C0C, 32'h99AA_BBCC, int'(BT), 0);
      drain();
      chk_errs();
      stall_mode = 1;
      rd(32'h0000_0D00, 32'hF00D_CAFE, 1, 0);
      drain();
      stall_mode = 0;
      repeat (25) @(posedge clk);
      #1;
      rand_bp = 1;
      max_gap = 3;
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(4) == 0) begin
            b = 8'($urandom_range(255));
            if (b == 8'h57 || b == 8'h52) b = 8'h00;
            send_byte(b);
            exp_ferr++;
         end
         if ($urandom_range(1) == 0) wr($urandom, $urandom, $urandom_range(8), $urandom_range(9) == 0);
         else rd($urandom, $urandom, $urandom_range(8), $urandom_range(9) == 0);
         drain();
      end
      rand_bp = 0;
      max_gap = 0;
      repeat (5) @(posedge clk);
      #1 chk_errs();
      send_byte(8'h52);
      send_byte(8'h11);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_outs_zero("rst_addr_phase");
      @(posedge clk);
      #1 rst = 1'b0;
      expect_txn(0, 32'h0000_0E00, 32'd0, 0, 1);
      q_tx.delete();
      exp_berr--;
      send_rd(32'h0000_0E00);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_bus_phase_req", {62'd0, io.reg_wr, io.reg_rd}, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (int'(BT) + 20) @(posedge clk);
      #1 chk_errs();
      rd(32'h0000_0F00, 32'h0123_4567, 2, 0);
      drain();
      chk_errs();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
